// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divider ratio-change scheduler.
package freq_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_WAIT_WRAP = 3'd2,
        ST_LOAD      = 3'd3,
        ST_ACK       = 3'd4
    } state_t;

    localparam int FD_NUM_REQ       = 4;
    localparam int FD_RATIO_W       = 5;
    localparam int FD_DEFAULT_RATIO = 10;
    localparam int FD_MIN_RATIO     = 2;
    localparam int TIMEOUT_CYC      = 64;
    localparam int TIMEOUT_W        = $clog2(TIMEOUT_CYC);

    // Round-robin successor of a requester index, wrapping n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and walks
// upward with wrap-around; the first asserted request wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Circular priority search starting at the pointer.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[c]) begin
                o_valid    = 1'b1;
                o_grant[c] = 1'b1;
                o_idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Ratio-change scheduler for the frequency divider: arbitrates requesters
// round-robin and applies the winning ratio only at a divider period wrap.
// Optional build macro FREQ_DIV_CTRL_TIMEOUT_EN: stop waiting for a wrap
// after TIMEOUT_CYC cycles, load anyway and flag err with the ack.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int NUM_REQ       = FD_NUM_REQ,
    parameter int RATIO_W       = FD_RATIO_W,
    parameter int DEFAULT_RATIO = FD_DEFAULT_RATIO,
    parameter int MIN_RATIO     = FD_MIN_RATIO
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*RATIO_W-1:0] req_ratio,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       err,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    input  logic                       div_wrap,
    output logic [RATIO_W-1:0]         div_ratio,
    output logic                       div_load
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               r_state;
    state_t               w_next_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [RATIO_W-1:0]   r_ratio;
    logic                 r_err_pend;
    logic [RATIO_W-1:0]   r_div_ratio;
    logic                 r_div_load;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_err;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_valid;
    logic [RATIO_W-1:0]   w_gnt_ratio;
    logic                 w_reject;
    logic                 w_same;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   w_ack_vec;
    logic                 w_err_now;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_onehot),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    assign w_gnt_ratio = req_ratio[int'(w_gnt_idx)*RATIO_W +: RATIO_W];
    assign w_reject    = (w_gnt_ratio < RATIO_W'(MIN_RATIO));
    assign w_same      = (w_gnt_ratio == r_div_ratio);

    // The ARB-to-ACK shortcut acks the fresh grant; every other ack uses the
    // latched owner and error flag.
    assign w_ack_vec = (r_state == ST_ARB) ? w_gnt_onehot : (NUM_REQ'(1) << r_owner);
    assign w_err_now = (r_state == ST_ARB) ? w_reject : r_err_pend;

`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_to_cnt;

    // Counts cycles spent in WAIT_WRAP; cleared while arbitrating so each
    // wait starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ARB) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT_WRAP) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT_WRAP) &&
                       (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req) w_next_state = ST_ARB;
            end
            ST_ARB: begin
                if (!w_gnt_valid)          w_next_state = ST_IDLE;
                else if (w_reject || w_same) w_next_state = ST_ACK;
                else                       w_next_state = ST_WAIT_WRAP;
            end
            ST_WAIT_WRAP: begin
                if (div_wrap || w_timeout) w_next_state = ST_LOAD;
            end
            ST_LOAD: w_next_state = ST_ACK;
            ST_ACK:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Registered handshake outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy     <= 1'b0;
            r_div_load <= 1'b0;
            r_ack      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy     <= (w_next_state != ST_IDLE);
            r_div_load <= (r_state == ST_WAIT_WRAP) && (w_next_state == ST_LOAD);
            r_ack      <= (w_next_state == ST_ACK) ? w_ack_vec : '0;
            r_err      <= (w_next_state == ST_ACK) && w_err_now;
        end
    end

    // Latch the winner in ARB; a wait timeout marks the request as erred.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= '0;
            r_ratio    <= '0;
            r_err_pend <= 1'b0;
        end else if (r_state == ST_ARB && w_gnt_valid) begin
            r_owner    <= w_gnt_idx;
            r_ratio    <= w_gnt_ratio;
            r_err_pend <= w_reject;
        end else if (w_timeout && !div_wrap) begin
            r_err_pend <= 1'b1;
        end
    end

    // Ratio presented to the divider changes only when entering LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_ratio <= RATIO_W'(DEFAULT_RATIO);
        end else if (r_state == ST_WAIT_WRAP && w_next_state == ST_LOAD) begin
            r_div_ratio <= r_ratio;
        end
    end

    // Round-robin pointer advances past the owner once it is acked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (r_state == ST_ACK) begin
            r_ptr <= IDX_W'(rr_next(int'(r_owner), NUM_REQ));
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign div_ratio = r_div_ratio;
    assign div_load  = r_div_load;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_freq_div_ctrl;

    localparam int N  = 4;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*RW-1:0] req_ratio;
    logic            div_wrap;
    logic [N-1:0]    ack;
    logic            err;
    logic [1:0]      owner;
    logic            busy;
    logic [RW-1:0]   div_ratio;
    logic            div_load;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: round-robin pointer and ratio currently at the divider.
    int m_ptr;
    int m_div;

    freq_div_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_ratio (req_ratio),
        .ack       (ack),
        .err       (err),
        .owner     (owner),
        .busy      (busy),
        .div_wrap  (div_wrap),
        .div_ratio (div_ratio),
        .div_load  (div_load)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n   = 1'b0;
        req       = '0;
        div_wrap  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        m_ptr   = 0;
        m_div   = 10;
    endtask

    // One full transaction for requester w, starting at an IDLE sample point
    // with req[w] already driven. The requester drops req on seeing ack.
    task automatic run_txn(input int w, input int exp_err, input int exp_load,
                           input int exp_div, input int delay,
                           input bit wrap_in_arb, input bit drop_early);
        logic [N-1:0] exp_ack;
        bit early;
        exp_ack = N'(1) << w;
        tick();
        check("arb_busy", busy, 1);
        if (wrap_in_arb) div_wrap = 1'b1;
        tick();
        div_wrap = 1'b0;
        if (exp_load == 0) begin
            check("fast_ack", ack, exp_ack);
            check("fast_err", err, exp_err);
            check("fast_noload", div_load, 0);
            check("fast_owner", owner, w);
            check("fast_ratio", div_ratio, exp_div);
            req[w] = 1'b0;
        end else begin
            check("wait_quiet", {ack, div_load, busy}, {4'b0, 1'b0, 1'b1});
            if (drop_early) req[w] = 1'b0;
            early = 1'b0;
            for (int i = 0; i < delay; i++) begin
                tick();
                if (div_load !== 1'b0 || ack !== '0) early = 1'b1;
            end
            check("no_early_load", early, 0);
            div_wrap = 1'b1;
            tick();
            div_wrap = 1'b0;
            check("load_pulse", div_load, 1);
            check("load_ratio", div_ratio, exp_div);
            check("load_noack", ack, 0);
            tick();
            check("ack_vec", ack, exp_ack);
            check("ack_err", err, exp_err);
            check("ack_noload", div_load, 0);
            check("ack_owner", owner, w);
            req[w] = 1'b0;
        end
        tick();
        check("idle_after", {ack, busy, err}, 0);
        m_ptr = (w + 1) % N;
        if (exp_load != 0) m_div = exp_div;
    endtask

    typedef struct {
        int idx;
        int ratio;
        int delay;
        bit wrap_in_arb;
        int exp_err;
        int exp_load;
        int exp_div;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit bad;
        int w;
        int r;
        logic [N-1:0] exp_ack_to;

        vecs[0] = '{idx: 1, ratio: 6,  delay: 5, wrap_in_arb: 0, exp_err: 0, exp_load: 1, exp_div: 6};
        vecs[1] = '{idx: 2, ratio: 1,  delay: 0, wrap_in_arb: 0, exp_err: 1, exp_load: 0, exp_div: 6};
        vecs[2] = '{idx: 2, ratio: 6,  delay: 0, wrap_in_arb: 0, exp_err: 0, exp_load: 0, exp_div: 6};
        vecs[3] = '{idx: 0, ratio: 31, delay: 2, wrap_in_arb: 0, exp_err: 0, exp_load: 1, exp_div: 31};
        vecs[4] = '{idx: 3, ratio: 0,  delay: 0, wrap_in_arb: 0, exp_err: 1, exp_load: 0, exp_div: 31};
        vecs[5] = '{idx: 3, ratio: 2,  delay: 3, wrap_in_arb: 1, exp_err: 0, exp_load: 1, exp_div: 2};
        vecs[6] = '{idx: 1, ratio: 10, delay: 0, wrap_in_arb: 0, exp_err: 0, exp_load: 1, exp_div: 10};
        vecs[7] = '{idx: 0, ratio: 10, delay: 0, wrap_in_arb: 0, exp_err: 0, exp_load: 0, exp_div: 10};

        req_ratio = '0;
        do_reset();

        // Reset state and 20 idle cycles with no change.
        check("rst_ratio", div_ratio, 10);
        check("rst_pulses", {ack, err, div_load, busy}, 0);
        check("rst_owner", owner, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (div_ratio !== 5'd10 || ack !== '0 || err !== 1'b0 ||
                div_load !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("idle_stable", bad, 0);

        // Directed single-requester vectors.
        for (int v = 0; v < 8; v++) begin
            req_ratio[vecs[v].idx*RW +: RW] = RW'(vecs[v].ratio);
            req[vecs[v].idx] = 1'b1;
            run_txn(vecs[v].idx, vecs[v].exp_err, vecs[v].exp_load, vecs[v].exp_div,
                    vecs[v].delay, vecs[v].wrap_in_arb, 1'b0);
        end

        // Fairness: all four held from a fresh pointer -> served 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) req_ratio[i*RW +: RW] = RW'(3 + i);
        req = 4'hF;
        for (int k = 0; k < N; k++) run_txn(k, 0, 1, 3 + k, 7, 1'b0, k == 1);
        // Pointer wrapped to 0: requester 0 (equal ratio) wins before 2.
        req_ratio[0*RW +: RW] = 5'd6;
        req_ratio[2*RW +: RW] = 5'd9;
        req = 4'b0101;
        run_txn(0, 0, 0, 6, 0, 1'b0, 1'b0);
        run_txn(2, 0, 1, 9, 4, 1'b0, 1'b0);

        // Reset during WAIT_WRAP aborts with no ack or load afterwards.
        req_ratio[1*RW +: RW] = 5'd20;
        req[1] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ratio", div_ratio, 10);
        check("midrst_pulses", {ack, div_load, err}, 0);
        req = '0;
        tick();
        reset_n = 1'b1;
        m_ptr = 0;
        m_div = 10;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            div_wrap = (i % 3 == 0);
            tick();
            if (ack !== '0 || div_load !== 1'b0 || busy !== 1'b0 || div_ratio !== 5'd10) bad = 1'b1;
        end
        div_wrap = 1'b0;
        check("midrst_silent", bad, 0);

        // Randomized traffic against the transaction-level model.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(1, 0) == 1) begin
                    case ($urandom_range(7, 0))
                        0:       r = int'($urandom_range(1, 0));
                        1:       r = m_div;
                        default: r = int'($urandom_range(31, 2));
                    endcase
                    req_ratio[i*RW +: RW] = RW'(r);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                req_ratio[0 +: RW] = 5'd12;
                req[0] = 1'b1;
            end
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            r = int'(req_ratio[w*RW +: RW]);
            if (r < 2)           run_txn(w, 1, 0, m_div, 0, 1'b0, 1'b0);
            else if (r == m_div) run_txn(w, 0, 0, m_div, 0, 1'b0, 1'b0);
            else run_txn(w, 0, 1, r, int'($urandom_range(12, 0)),
                         $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0);
        end

        // Missing wrap: timeout build loads after 64 cycles, default waits.
        do_reset();
        req_ratio[3*RW +: RW] = 5'd7;
        req[3] = 1'b1;
        tick();
        tick();
        check("to_wait", {busy, div_load}, 2'b10);
        bad = 1'b0;
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
        for (int i = 0; i < 63; i++) begin
            tick();
            if (div_load !== 1'b0 || ack !== '0) bad = 1'b1;
        end
        check("to_early", bad, 0);
        tick();
        check("to_load", div_load, 1);
        check("to_ratio", div_ratio, 7);
        tick();
        exp_ack_to = 4'b1000;
        check("to_ack", ack, exp_ack_to);
        check("to_err", err, 1);
        req = '0;
        tick();
        check("to_idle", busy, 0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b1 || div_load !== 1'b0 || ack !== '0) bad = 1'b1;
        end
        check("nowrap_hold", bad, 0);
        exp_ack_to = '0;
        check("nowrap_noack", ack, exp_ack_to);
        check("nowrap_ratio", div_ratio, 10);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
